// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master/target pair.
//   i2c_state_e        : 4-bit protocol state encoding (same for both ends)
//   I2C_ACK / I2C_NACK : SDL level of the 9th bit
//   I2C_DEV_ID_DEFAULT : address the target answers unless overridden
//   ptr_next()         : register-pointer step, wraps 8'hFF -> 8'h00
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_DEV_ADDR  = 4'd1,
      ST_DEV_ACK   = 4'd2,
      ST_REG_ADDR  = 4'd3,
      ST_REG_ACK   = 4'd4,
      ST_WRITE     = 4'd5,
      ST_WRITE_ACK = 4'd6,
      ST_READ      = 4'd7,
      ST_READ_ACK  = 4'd8
   } i2c_state_e;

   localparam logic       I2C_ACK            = 1'b0;
   localparam logic       I2C_NACK           = 1'b1;
   localparam logic [6:0] I2C_DEV_ID_DEFAULT = 7'h48;

   function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
      return ptr + 8'd1;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ---------------------------------------------------------------------------
// i2c_line_sync
// Synchronizer plus edge detector for one bus line (SCL or SDL).
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   line_i   : raw pad level
//   level_o  : synchronized level
//   rise_o   : one-cycle pulse on a synchronized 0->1
//   fall_o   : one-cycle pulse on a synchronized 1->0
// The chain resets to 1 (released bus) so leaving reset on an idle bus
// produces no spurious edges.
// ---------------------------------------------------------------------------
module i2c_line_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], line_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// ---------------------------------------------------------------------------
// i2c_slave
// I2C target with a byte-wide register-file interface. SCL/SDL are
// oversampled on the system clock; no clock stretching.
//   clock_freq_i : system clock (>= 10x SCL)
//   reset_i      : asynchronous active-high reset
//   scl_i        : bus clock
//   sdl_in_i     : bus data as seen at the pad
//   sdl_oe_o     : 1 = pull SDL low, 0 = release
//   reg_addr_o   : register pointer
//   wr_data_o    : last byte written by the master
//   wr_en_o      : one-cycle write strobe (wr_data_o / reg_addr_o valid)
//   rd_en_o      : one-cycle read request for reg_addr_o
//   rd_data_i    : read byte, sampled the cycle after rd_en_o
//   busy_o       : matched address until STOP / abort
// Optional feature: define I2C_SLAVE_AUTO_INC_EN to advance the pointer
// after every written byte and every ACKed read byte.
//
// state        | meaning
// -------------+-------------------------------------------------------
// ST_IDLE      | bus ignored until START
// ST_DEV_ADDR  | shifting in 7-bit ID + R/W
// ST_DEV_ACK   | driving ACK on the 9th clock; read issues rd_en here
// ST_REG_ADDR  | shifting in register pointer
// ST_REG_ACK   | driving ACK for pointer byte
// ST_WRITE     | shifting in data byte
// ST_WRITE_ACK | driving ACK for data byte
// ST_READ      | shifting out data byte on SCL falls
// ST_READ_ACK  | SDL released, sampling master ACK/NACK
// ---------------------------------------------------------------------------
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ID      = I2C_DEV_ID_DEFAULT,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clock_freq_i,
   input  logic       reset_i,
   input  logic       scl_i,
   input  logic       sdl_in_i,
   output logic       sdl_oe_o,
   output logic [7:0] reg_addr_o,
   output logic [7:0] wr_data_o,
   output logic       wr_en_o,
   output logic       rd_en_o,
   input  logic [7:0] rd_data_i,
   output logic       busy_o
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sdl_lvl, sdl_rise, sdl_fall;

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk_i   (clock_freq_i),
      .rst_i   (reset_i),
      .line_i  (scl_i),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sdl_sync (
      .clk_i   (clock_freq_i),
      .rst_i   (reset_i),
      .line_i  (sdl_in_i),
      .level_o (sdl_lvl),
      .rise_o  (sdl_rise),
      .fall_o  (sdl_fall)
   );

   logic start_det, stop_det;
   assign start_det = sdl_fall & scl_lvl;
   assign stop_det  = sdl_rise & scl_lvl;

   i2c_state_e state_q;
   logic [2:0] bit_cnt_q;
   logic [7:0] shift_q;
   logic [7:0] reg_addr_q;
   logic [7:0] wr_data_q;
   logic       wr_en_q;
   logic       rd_en_q;
   logic       rd_load_q;
   logic       sdl_oe_q;
   logic       busy_q;
   logic       rw_q;
   logic       ack_rise_q;

   logic [7:0] rx_byte;
   assign rx_byte = {shift_q[6:0], sdl_lvl};

   always_ff @(posedge clock_freq_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         reg_addr_q <= 8'h00;
         wr_data_q  <= 8'h00;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_load_q  <= 1'b0;
         sdl_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= 1'b0;
         ack_rise_q <= 1'b0;
      end else begin
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_load_q <= rd_en_q;

         // The register file answers one cycle after rd_en; capture then.
         if (rd_load_q) begin
            shift_q <= rd_data_i;
         end

`ifdef I2C_SLAVE_AUTO_INC_EN
         if (wr_en_q) begin
            reg_addr_q <= ptr_next(reg_addr_q);
         end
`endif

         if (start_det) begin
            state_q    <= ST_DEV_ADDR;
            bit_cnt_q  <= 3'd7;
            sdl_oe_q   <= 1'b0;
            ack_rise_q <= 1'b0;
         end else if (stop_det) begin
            state_q    <= ST_IDLE;
            sdl_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_rise_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  sdl_oe_q <= 1'b0;
               end

               ST_DEV_ADDR: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte;
                     if (bit_cnt_q == 3'd0) begin
                        if (rx_byte[7:1] == DEV_ID) begin
                           state_q    <= ST_DEV_ACK;
                           rw_q       <= rx_byte[0];
                           busy_q     <= 1'b1;
                           ack_rise_q <= 1'b0;
                        end else begin
                           state_q <= ST_IDLE;
                           busy_q  <= 1'b0;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                     end
                  end
               end

               // First fall after the 8th bit drives ACK, the 9th rise is
               // remembered, and the following fall ends the ACK slot.
               ST_DEV_ACK: begin
                  if (scl_fall && !ack_rise_q) begin
                     sdl_oe_q <= ~I2C_ACK;
                  end else if (scl_rise) begin
                     ack_rise_q <= 1'b1;
                     if (rw_q) begin
                        rd_en_q   <= 1'b1;
                        state_q   <= ST_READ;
                        bit_cnt_q <= 3'd7;
                     end
                  end else if (scl_fall) begin
                     sdl_oe_q  <= 1'b0;
                     state_q   <= ST_REG_ADDR;
                     bit_cnt_q <= 3'd7;
                  end
               end

               ST_REG_ADDR: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte;
                     if (bit_cnt_q == 3'd0) begin
                        reg_addr_q <= rx_byte;
                        state_q    <= ST_REG_ACK;
                        ack_rise_q <= 1'b0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                     end
                  end
               end

               ST_REG_ACK, ST_WRITE_ACK: begin
                  if (scl_fall && !ack_rise_q) begin
                     sdl_oe_q <= ~I2C_ACK;
                  end else if (scl_rise) begin
                     ack_rise_q <= 1'b1;
                  end else if (scl_fall) begin
                     sdl_oe_q  <= 1'b0;
                     state_q   <= ST_WRITE;
                     bit_cnt_q <= 3'd7;
                  end
               end

               ST_WRITE: begin
                  if (scl_rise) begin
                     shift_q <= rx_byte;
                     if (bit_cnt_q == 3'd0) begin
                        wr_data_q  <= rx_byte;
                        wr_en_q    <= 1'b1;
                        state_q    <= ST_WRITE_ACK;
                        ack_rise_q <= 1'b0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                     end
                  end
               end

               // Open-drain: a 0 bit pulls the line, a 1 bit releases it.
               ST_READ: begin
                  if (scl_fall) begin
                     sdl_oe_q <= ~shift_q[7];
                     shift_q  <= {shift_q[6:0], 1'b1};
                  end else if (scl_rise) begin
                     if (bit_cnt_q == 3'd0) begin
                        state_q <= ST_READ_ACK;
                     end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                     end
                  end
               end

               ST_READ_ACK: begin
                  if (scl_fall) begin
                     sdl_oe_q <= 1'b0;
                  end else if (scl_rise) begin
                     if (sdl_lvl == I2C_ACK) begin
`ifdef I2C_SLAVE_AUTO_INC_EN
                        reg_addr_q <= ptr_next(reg_addr_q);
`endif
                        rd_en_q   <= 1'b1;
                        state_q   <= ST_READ;
                        bit_cnt_q <= 3'd7;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end
               end

               default: begin
                  state_q  <= ST_IDLE;
                  sdl_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sdl_oe_o   = sdl_oe_q;
   assign reg_addr_o = reg_addr_q;
   assign wr_data_o  = wr_data_q;
   assign wr_en_o    = wr_en_q;
   assign rd_en_o    = rd_en_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave
// Bit-banged I2C master plus a small register file around i2c_slave.
// Expected strobes go into exp_q when a transaction is issued and are
// popped as the DUT raises wr_en/rd_en; expected read bytes go into rdq.
// ---------------------------------------------------------------------------
module tb_i2c_slave;

   localparam int Q = 6;
`ifdef I2C_SLAVE_AUTO_INC_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct packed {
      logic       is_rd;
      logic [7:0] addr;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sdl_bus;
   logic       sdl_oe;
   logic [7:0] reg_addr;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       busy;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   oe_cnt = 0;
   exp_t exp_q[$];
   logic [7:0] rdq[$];
   logic [7:0] mem [256];

   always #5 clk = ~clk;

   assign sdl_bus = sda_m & ~sdl_oe;

   i2c_slave #(.DEV_ID(7'h48), .SYNC_STAGES(2)) dut (
      .clock_freq_i (clk),
      .reset_i      (rst),
      .scl_i        (scl_m),
      .sdl_in_i     (sdl_bus),
      .sdl_oe_o     (sdl_oe),
      .reg_addr_o   (reg_addr),
      .wr_data_o    (wr_data),
      .wr_en_o      (wr_en),
      .rd_en_o      (rd_en),
      .rd_data_i    (rd_data),
      .busy_o       (busy)
   );

   // Register file: preloaded while reset is held.
   always @(posedge clk) begin
      if (rst) begin
         mem[8'h20] <= 8'h3C;
         mem[8'h21] <= 8'hC3;
         mem[8'h30] <= 8'h0F;
      end else begin
         if (wr_en) mem[reg_addr] <= wr_data;
         if (rd_en) rd_data <= mem[reg_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sdl_oe) oe_cnt++;
      if (wr_en || rd_en) begin
         chk("strobe_excl", 32'(wr_en & rd_en), 0);
         chk("strobe_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("strobe_kind", 32'(rd_en), 32'(e.is_rd));
            chk("strobe_addr", 32'(reg_addr), 32'(e.addr));
            if (!e.is_rd) chk("wr_data", 32'(wr_data), 32'(e.data));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q);
      s = sdl_bus;  tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic rd_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(nack, s);
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back('{is_rd: 1'b0, addr: a, data: d});
   endtask

   task automatic push_rd(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back('{is_rd: 1'b1, addr: a, data: 8'h00});
      rdq.push_back(d);
   endtask

   task automatic check_rd(input logic [7:0] got);
      chk("rdq_nonempty", 32'(rdq.size() > 0), 1);
      if (rdq.size() > 0) chk("rd_byte", 32'(got), 32'(rdq.pop_front()));
   endtask

   task automatic write_txn(input logic [7:0] ra, input logic [7:0] d, input string tag);
      logic a;
      bus_start();
      wr_byte(8'h90, a); chk({tag, "_ack_dev"}, 32'(a), 0);
      wr_byte(ra, a);    chk({tag, "_ack_reg"}, 32'(a), 0);
      push_wr(ra, d);
      wr_byte(d, a);     chk({tag, "_ack_dat"}, 32'(a), 0);
      bus_stop();
   endtask

   initial begin
      logic       a;
      logic       s;
      logic [7:0] d;
      int         snap;

      rst = 1'b1;
      tick(5);
      rst = 1'b0;
      tick(4);
      chk("rst_sdl_oe", 32'(sdl_oe), 0);
      chk("rst_reg_addr", 32'(reg_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_busy", 32'(busy), 0);

      // Single write with busy tracking.
      bus_start();
      wr_byte(8'h90, a); chk("w_ack_dev", 32'(a), 0);
      chk("w_busy", 32'(busy), 1);
      wr_byte(8'h10, a); chk("w_ack_reg", 32'(a), 0);
      push_wr(8'h10, 8'hA5);
      wr_byte(8'hA5, a); chk("w_ack_dat", 32'(a), 0);
      bus_stop();
      tick(4);
      chk("w_busy_after", 32'(busy), 0);
      chk("w_ptr", 32'(reg_addr), AUTO ? 32'h11 : 32'h10);

      // Wrong address: the line must never be pulled.
      snap = oe_cnt;
      bus_start();
      wr_byte(8'h92, a); chk("wa_nack_dev", 32'(a), 1);
      chk("wa_busy", 32'(busy), 0);
      wr_byte(8'h55, a); chk("wa_nack_dat", 32'(a), 1);
      bus_stop();
      tick(4);
      chk("wa_oe_cycles", 32'(oe_cnt - snap), 0);

      // Pointer write, repeated START, single read with NACK.
      bus_start();
      wr_byte(8'h90, a); chk("r_ack_dev", 32'(a), 0);
      wr_byte(8'h20, a); chk("r_ack_reg", 32'(a), 0);
      bus_start();
      push_rd(8'h20, 8'h3C);
      wr_byte(8'h91, a); chk("r_ack_rdev", 32'(a), 0);
      rd_byte(1'b1, d);
      check_rd(d);
      tick(2);
      chk("r_oe_after_nack", 32'(sdl_oe), 0);
      chk("r_ptr_kept", 32'(reg_addr), 32'h20);
      bus_stop();
      tick(4);
      chk("r_busy_after", 32'(busy), 0);

      // Two-byte read: ACK then NACK.
      bus_start();
      push_rd(8'h20, 8'h3C);
      push_rd(AUTO ? 8'h21 : 8'h20, AUTO ? 8'hC3 : 8'h3C);
      wr_byte(8'h91, a); chk("r2_ack_dev", 32'(a), 0);
      rd_byte(1'b0, d);
      check_rd(d);
      rd_byte(1'b1, d);
      check_rd(d);
      bus_stop();

      // Burst write across the pointer wrap.
      bus_start();
      wr_byte(8'h90, a); chk("b_ack_dev", 32'(a), 0);
      wr_byte(8'hFE, a); chk("b_ack_reg", 32'(a), 0);
      push_wr(8'hFE, 8'h11);
      wr_byte(8'h11, a); chk("b_ack_d0", 32'(a), 0);
      push_wr(AUTO ? 8'hFF : 8'hFE, 8'h22);
      wr_byte(8'h22, a); chk("b_ack_d1", 32'(a), 0);
      push_wr(AUTO ? 8'h00 : 8'hFE, 8'h33);
      wr_byte(8'h33, a); chk("b_ack_d2", 32'(a), 0);
      bus_stop();
      tick(4);
      chk("b_ptr_final", 32'(reg_addr), AUTO ? 32'h01 : 32'hFE);

      // STOP after four data bits, then a clean transaction.
      bus_start();
      wr_byte(8'h90, a); chk("s_ack_dev", 32'(a), 0);
      wr_byte(8'h40, a); chk("s_ack_reg", 32'(a), 0);
      bit_xfer(1'b1, s);
      bit_xfer(1'b0, s);
      bit_xfer(1'b1, s);
      bit_xfer(1'b0, s);
      bus_stop();
      tick(4);
      chk("s_oe", 32'(sdl_oe), 0);
      chk("s_busy", 32'(busy), 0);
      chk("s_q_empty", 32'(exp_q.size()), 0);
      write_txn(8'h41, 8'h77, "s_next");

      // Reset while the target pulls SDL low during a read.
      bus_start();
      wr_byte(8'h90, a); chk("x_ack_dev", 32'(a), 0);
      wr_byte(8'h30, a); chk("x_ack_reg", 32'(a), 0);
      bus_start();
      push_rd(8'h30, 8'h0F);
      wr_byte(8'h91, a); chk("x_ack_rdev", 32'(a), 0);
      chk("x_driving_zero", 32'(sdl_oe), 1);
      void'(rdq.pop_front());
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("x_oe_async", 32'(sdl_oe), 0);
      chk("x_reg_addr", 32'(reg_addr), 0);
      chk("x_wr_data", 32'(wr_data), 0);
      chk("x_wr_en", 32'(wr_en), 0);
      chk("x_rd_en", 32'(rd_en), 0);
      chk("x_busy", 32'(busy), 0);
      tick(3);
      rst = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(4 * Q);
      write_txn(8'h50, 8'h99, "x_next");

      tick(10);
      chk("final_q_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

I2C target (slave) that sits on the same two-wire bus as `i2c_master` and answers its transactions. It oversamples SCL/SDL on the system clock, detects START/STOP, and matches a 7-bit device ID. It exposes an 8-bit register pointer plus byte read/write strobes to a local register file, so the design can loop back against the master or act as a target device.

## Interface
Parameters:
- `DEV_ID`, 7'h48, device address this target ACKs.
- `SYNC_STAGES`, 2, flops in each SCL/SDL input synchronizer (≥2).

Ports:
- `clock_freq`  in  1  system clock; must be ≥10× SCL rate.
- `reset`  in  1  asynchronous, active-high.
- `scl`  in  1  bus clock (input only; no clock stretching).
- `sdl_in`  in  1  bus data as read from the pad.
- `sdl_oe`  out  1  1 = pull SDL low (open-drain); 0 = release.
- `reg_addr`  out  8  current register pointer.
- `wr_data`  out  8  byte received from master.
- `wr_en`  out  1  one-cycle pulse; `wr_data`/`reg_addr` valid.
- `rd_en`  out  1  one-cycle pulse requesting byte at `reg_addr`.
- `rd_data`  in  8  sampled exactly 1 cycle after `rd_en`.
- `busy`  out  1  high from matched address until STOP/abort.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then 1 edge-detect register: `scl_rise`, `scl_fall`, `sdl_rise`, `sdl_fall`.
- START = `sdl_fall` while SCL high. STOP = `sdl_rise` while SCL high. Both override every state.
- Data sampled on `scl_rise`. `sdl_oe` changes only on `scl_fall` (or on reset/STOP/START).
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- IDLE: START → DEV_ADDR, `bit_count`=7.
- DEV_ADDR: shift 8 bits MSB-first. After bit 0: addr[7:1]==`DEV_ID` → DEV_ACK; else → IDLE, SDL never driven.
- DEV_ACK: `sdl_oe`=1 for the 9th clock. R/W=0 → REG_ADDR. R/W=1 → `rd_en` pulse on that 9th `scl_rise`, then READ.
- REG_ADDR: 8 bits → `reg_addr` loaded on 8th `scl_rise`; REG_ACK (drive ACK) → WRITE.
- WRITE: 8 bits → `wr_data` and `wr_en` pulse on 8th `scl_rise`; WRITE_ACK (drive ACK); pointer increments after `wr_en` → WRITE.
- READ: shift register loaded from `rd_data`; MSB driven from next `scl_fall` (`sdl_oe` = ~bit). After 8 bits release SDL → READ_ACK.
- READ_ACK: sample SDL on `scl_rise`. ACK (0) → pointer increment, `rd_en` pulse, READ. NACK (1) → IDLE (wait STOP/START).
- Repeated START mid-transaction → DEV_ADDR; `reg_addr` retained (write-pointer-then-read works).
- STOP anywhere → IDLE, `sdl_oe`=0 in same cycle, `busy`=0.
- Pointer arithmetic: 8-bit, wraps 8'hFF → 8'h00.

## Timing
- Reset values: `sdl_oe`=0, `reg_addr`=8'h00, `wr_data`=8'h00, `wr_en`=0, `rd_en`=0, `busy`=0, state IDLE.
- Reset asserted mid-transfer: SDL released immediately (async), shift/count cleared; no partial `wr_en`.
- Bus-to-detect latency: `SYNC_STAGES`+1 cycles.
- `wr_en`/`rd_en` never high in same cycle; each exactly 1 cycle wide.
- `rd_data` must be stable the cycle after `rd_en`; no wait states.
- `sdl_oe` change lags `scl_fall` detect by 1 cycle (registered output).
- START and STOP on same sample impossible (single SDL edge); START wins if edge detection ambiguous after reset.

## Configuration
- `I2C_SLAVE_AUTO_INC_EN` defined: pointer increments after every written byte and every ACKed read byte (behaviour above).
- Undefined: pointer changes only in REG_ADDR; repeated writes overwrite `reg_addr`, repeated reads return the same register.

## Structure
- Package `i2c_pkg`: state encoding typedef (4-bit, shared with `i2c_master`), ACK/NACK constants, default `DEV_ID`.
- Sub-module `i2c_line_sync`: synchronizer + edge detect for one line; instantiated twice (SCL, SDL).

## Test plan
- Write: START, 0x90, ACK, reg 0x10, ACK, data 0xA5, STOP → one `wr_en` with `reg_addr`=0x10, `wr_data`=0xA5; ACK driven on all three 9th clocks.
- Wrong address: START, 0x92 → `sdl_oe` stays 0 whole frame, no strobes, `busy`=0.
- Pointer+read: write reg 0x20, repeated START, 0x91, bench returns 0x3C → SDL shows 0x3C MSB-first; master NACK → IDLE.
- Burst auto-inc: write reg 0xFE then 0x11,0x22,0x33 → `wr_en` at 0xFE, 0xFF, 0x00 (wrap); without macro all at 0xFE.
- STOP mid-byte after 4 data bits → IDLE, `sdl_oe`=0, no `wr_en`; next transaction succeeds.
- `reset` asserted during READ while driving 0 → `sdl_oe`=0 same cycle; all outputs at reset values.
